// File: rtl/fft_core.sv
// ---------------------------------------------------------------------------
// fft_core
//   Radix-2 decimation-in-time FFT over two ping-pong complex memories.
//   Samples are loaded into mem0 (two complex words per load cycle), a start
//   request then runs log2(N) stages of N/2 butterflies, one per enabled
//   cycle, and the natural-order spectrum ends up in mem1.
//
// Parameters
//   N : transform length (twiddle ROM holds the eight-point circle, N = 8)
//   I : integer bits of the Q(I).(F) sample format
//   F : fraction bits of the Q(I).(F) sample format
//
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous, active-low; clears state, done, pointers, memories
//   enable   : clock enable, low freezes everything except reset
//   go       : start request, needs a low phase between two starts
//   mem0_load, mem1_load              : load strobes for mem0 / mem1
//   memX_external_load1/2_real/_imag  : two complex words written per strobe
//   done     : registered, high once the transform has completed
// ---------------------------------------------------------------------------
module fft_core #(
    parameter int N = 8,
    parameter int I = 8,
    parameter int F = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           go,
    input  logic           mem0_load,
    input  logic           mem1_load,
    input  logic [I+F-1:0] mem0_external_load1_real,
    input  logic [I+F-1:0] mem0_external_load1_imag,
    input  logic [I+F-1:0] mem0_external_load2_real,
    input  logic [I+F-1:0] mem0_external_load2_imag,
    input  logic [I+F-1:0] mem1_external_load1_real,
    input  logic [I+F-1:0] mem1_external_load1_imag,
    input  logic [I+F-1:0] mem1_external_load2_real,
    input  logic [I+F-1:0] mem1_external_load2_imag,
    output logic           done
);

    localparam int W    = I + F;
    localparam int LOGN = $clog2(N);
    localparam int BW   = (LOGN > 1) ? LOGN - 1 : 1;
    localparam int SW   = (LOGN > 1) ? $clog2(LOGN) : 1;

    localparam logic [BW-1:0] LAST_BFLY  = BW'(N / 2 - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN - 1);

    // sqrt(1/2) in Q0.32, rounded to F fraction bits for the 45-degree twiddles
    localparam logic [63:0] SQRT_HALF_Q32 = 64'h0000_0000_B504_F334;
    localparam logic [63:0] C45_WIDE = (SQRT_HALF_Q32 + (64'd1 << (31 - F))) >> (32 - F);

    localparam logic [W-1:0] ONE     = W'(64'd1 << F);
    localparam logic [W-1:0] NEG_ONE = ~ONE + 1'b1;
    localparam logic [W-1:0] C45     = W'(C45_WIDE);
    localparam logic [W-1:0] NEG_C45 = ~C45 + 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [BW-1:0]   bfly_q, bfly_d;
    logic            done_q, done_d;
    logic            armed_q, armed_d;
    logic [LOGN-1:0] ptr0_q, ptr1_q;

    logic [W-1:0] mem0_real [N];
    logic [W-1:0] mem0_imag [N];
    logic [W-1:0] mem1_real [N];
    logic [W-1:0] mem1_imag [N];

    logic [LOGN-1:0] bExt, hBit, hMask, topIdx, botIdx, rdTop, rdBot;
    logic [SW-1:0]   kShift;
    logic [BW-1:0]   kIdx;
    logic            srcIsMem0;
    logic [W-1:0]    aRe, aIm, bRe, bIm, wRe, wIm, tRe, tIm;
    logic [W-1:0]    newTopRe, newTopIm, newBotRe, newBotIm;
    logic [2*W-1:0]  pRR, pII, pRI, pIR;
    logic signed [2*W:0] sumRe, sumIm;

    function automatic logic [LOGN-1:0] bitRev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = x[LOGN-1-i];
        end
        return r;
    endfunction

    // Control: start qualification, butterfly/stage counters and done.
    // armed_q remembers that go has been seen low since the last start, so
    // holding go high across a completed transform cannot restart it.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        done_d  = done_q;
        armed_d = armed_q;
        if (!go) begin
            armed_d = 1'b1;
        end
        case (state_q)
            IDLE, DONE: begin
                if (go && armed_q && !mem0_load && !mem1_load) begin
                    state_d = RUN;
                    stage_d = '0;
                    bfly_d  = '0;
                    done_d  = 1'b0;
                    armed_d = 1'b0;
                end
            end
            RUN: begin
                if (bfly_q == LAST_BFLY) begin
                    bfly_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        state_d = DONE;
                        stage_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    bfly_d = bfly_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
            done_q  <= 1'b0;
            armed_q <= 1'b1;
        end else if (enable) begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end

    assign done = done_q;

    // Butterfly addressing. top clears bit s of the butterfly index and
    // shifts the upper part left by one, so bot is simply top with bit s set.
    always_comb begin
        bExt   = LOGN'(bfly_q);
        hBit   = LOGN'(1) << stage_q;
        hMask  = hBit - 1'b1;
        topIdx = ((bExt & ~hMask) << 1) | (bExt & hMask);
        botIdx = topIdx | hBit;
        kShift = LAST_STAGE - stage_q;
        kIdx   = BW'((bExt & hMask) << kShift);
        srcIsMem0 = ~stage_q[0];
        rdTop  = (stage_q == '0) ? bitRev(topIdx) : topIdx;
        rdBot  = (stage_q == '0) ? bitRev(botIdx) : botIdx;
    end

    // Even stages read mem0 and write mem1, odd stages the reverse
    always_comb begin
        if (srcIsMem0) begin
            aRe = mem0_real[rdTop];
            aIm = mem0_imag[rdTop];
            bRe = mem0_real[rdBot];
            bIm = mem0_imag[rdBot];
        end else begin
            aRe = mem1_real[rdTop];
            aIm = mem1_imag[rdTop];
            bRe = mem1_real[rdBot];
            bIm = mem1_imag[rdBot];
        end
    end

    // Twiddle ROM, W_k = cos(2*pi*k/N) - j*sin(2*pi*k/N)
    always_comb begin
        wRe = ONE;
        wIm = '0;
        case (kIdx)
            BW'(1): begin wRe = C45;     wIm = NEG_C45; end
            BW'(2): begin wRe = '0;      wIm = NEG_ONE; end
            BW'(3): begin wRe = NEG_C45; wIm = NEG_C45; end
            default: ;
        endcase
    end

    // Complex multiply and add/sub. Operands are sign-extended to 2W bits so
    // the low 2W bits of each unsigned product equal the signed product; the
    // sums are then truncated toward minus infinity by the arithmetic shift.
    always_comb begin
        pRR = {{W{wRe[W-1]}}, wRe} * {{W{bRe[W-1]}}, bRe};
        pII = {{W{wIm[W-1]}}, wIm} * {{W{bIm[W-1]}}, bIm};
        pRI = {{W{wRe[W-1]}}, wRe} * {{W{bIm[W-1]}}, bIm};
        pIR = {{W{wIm[W-1]}}, wIm} * {{W{bRe[W-1]}}, bRe};
        sumRe = {pRR[2*W-1], pRR} - {pII[2*W-1], pII};
        sumIm = {pRI[2*W-1], pRI} + {pIR[2*W-1], pIR};
        tRe = W'(sumRe >>> F);
        tIm = W'(sumIm >>> F);
        newTopRe = aRe + tRe;
        newTopIm = aIm + tIm;
        newBotRe = aRe - tRe;
        newBotIm = aIm - tIm;
    end

    // Memories and load pointers. A load pointer only advances on a cycle
    // where its load is actually accepted and falls back to zero otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                mem0_real[i] <= '0;
                mem0_imag[i] <= '0;
                mem1_real[i] <= '0;
                mem1_imag[i] <= '0;
            end
            ptr0_q <= '0;
            ptr1_q <= '0;
        end else if (enable) begin
            if (state_q != RUN && mem0_load) begin
                mem0_real[ptr0_q]        <= mem0_external_load1_real;
                mem0_imag[ptr0_q]        <= mem0_external_load1_imag;
                mem0_real[ptr0_q + 1'b1] <= mem0_external_load2_real;
                mem0_imag[ptr0_q + 1'b1] <= mem0_external_load2_imag;
                ptr0_q <= ptr0_q + LOGN'(2);
            end else begin
                ptr0_q <= '0;
            end
            if (state_q != RUN && mem1_load) begin
                mem1_real[ptr1_q]        <= mem1_external_load1_real;
                mem1_imag[ptr1_q]        <= mem1_external_load1_imag;
                mem1_real[ptr1_q + 1'b1] <= mem1_external_load2_real;
                mem1_imag[ptr1_q + 1'b1] <= mem1_external_load2_imag;
                ptr1_q <= ptr1_q + LOGN'(2);
            end else begin
                ptr1_q <= '0;
            end
            if (state_q == RUN) begin
                if (srcIsMem0) begin
                    mem1_real[topIdx] <= newTopRe;
                    mem1_imag[topIdx] <= newTopIm;
                    mem1_real[botIdx] <= newBotRe;
                    mem1_imag[botIdx] <= newBotIm;
                end else begin
                    mem0_real[topIdx] <= newTopRe;
                    mem0_imag[topIdx] <= newTopIm;
                    mem0_real[botIdx] <= newBotRe;
                    mem0_imag[botIdx] <= newBotIm;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_core.sv
// ---------------------------------------------------------------------------
// tb_fft_core
//   Self-checking bench for fft_core (N=8, Q8.8). Inputs are loaded into
//   mem0, the transform is started, and latency, done behaviour and the mem1
//   spectrum are compared against an in-place DIT FFT model computed with
//   plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_fft_core;

    localparam int N = 8;
    localparam int I = 8;
    localparam int F = 8;
    localparam int W = I + F;

    logic clk = 1'b0;
    logic reset, enable, go, mem0_load, mem1_load;
    logic [W-1:0] m0r1, m0i1, m0r2, m0i2, m1r1, m1i1, m1r2, m1i2;
    logic done;

    int testsRun  = 0;
    int failCount = 0;

    logic [W-1:0] inR [N];
    logic [W-1:0] inI [N];
    logic [W-1:0] expR [N];
    logic [W-1:0] expI [N];

    fft_core #(.N(N), .I(I), .F(F)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .go                       (go),
        .mem0_load                (mem0_load),
        .mem1_load                (mem1_load),
        .mem0_external_load1_real (m0r1),
        .mem0_external_load1_imag (m0i1),
        .mem0_external_load2_real (m0r2),
        .mem0_external_load2_imag (m0i2),
        .mem1_external_load1_real (m1r1),
        .mem1_external_load1_imag (m1i1),
        .mem1_external_load2_real (m1r2),
        .mem1_external_load2_imag (m1i2),
        .done                     (done)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where inputs change and
    // outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint wrapW(input longint v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return longint'(t);
    endfunction

    // Reference: bit-reverse the input, then an in-place radix-2 DIT FFT
    // with truncating fixed-point twiddle products and wrapping add/sub.
    task automatic computeModel();
        longint ar [N];
        longint ai [N];
        longint twr [4];
        longint twi [4];
        twr = '{256, 181, 0, -181};
        twi = '{0, -181, -256, -181};
        for (int i = 0; i < N; i++) begin
            logic [2:0] v;
            logic [2:0] rv;
            v  = i[2:0];
            rv = {v[0], v[1], v[2]};
            ar[i] = longint'($signed(inR[rv]));
            ai[i] = longint'($signed(inI[rv]));
        end
        for (int s = 0; s < 3; s++) begin
            int h;
            h = 1 << s;
            for (int b = 0; b < N / 2; b++) begin
                int top, bot, k;
                longint tr, ti, a0r, a0i;
                top = (b >> s) * 2 * h + (b & (h - 1));
                bot = top + h;
                k   = (b & (h - 1)) * (N / (2 * h));
                tr  = wrapW((twr[k] * ar[bot] - twi[k] * ai[bot]) >>> F);
                ti  = wrapW((twr[k] * ai[bot] + twi[k] * ar[bot]) >>> F);
                a0r = ar[top];
                a0i = ai[top];
                ar[top] = wrapW(a0r + tr);
                ai[top] = wrapW(a0i + ti);
                ar[bot] = wrapW(a0r - tr);
                ai[bot] = wrapW(a0i - ti);
            end
        end
        for (int i = 0; i < N; i++) begin
            expR[i] = ar[i][W-1:0];
            expI[i] = ai[i][W-1:0];
        end
    endtask

    // Stream inR/inI into mem0, two words per cycle; load is left low
    // afterwards without an extra edge so the caller may raise go at once.
    task automatic applyStimulus();
        for (int j = 0; j < N / 2; j++) begin
            mem0_load = 1'b1;
            m0r1 = inR[2*j];
            m0i1 = inI[2*j];
            m0r2 = inR[2*j+1];
            m0i2 = inI[2*j+1];
            tick();
        end
        mem0_load = 1'b0;
    endtask

    task automatic randomInput();
        for (int i = 0; i < N; i++) begin
            inR[i] = W'($urandom);
            inI[i] = W'($urandom);
        end
    endtask

    // Start edge, then count edges until done (bounded). An optional
    // enable-low window of stallLen edges starts stallAt edges into the run.
    task automatic startAndWait(input bit holdGo, input int stallAt, input int stallLen,
                                output int cycles);
        go = 1'b1;
        tick();
        if (!holdGo) go = 1'b0;
        checkOutput("done_clear_on_start", 32'(done), 32'd0);
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            if (cycles == stallAt) enable = 1'b0;
            if (cycles == stallAt + stallLen) enable = 1'b1;
            tick();
            cycles++;
        end
        enable = 1'b1;
    endtask

    task automatic checkMem1(input string tag);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("%s_re%0d", tag, i), 32'(dut.mem1_real[i]), 32'(expR[i]));
            checkOutput($sformatf("%s_im%0d", tag, i), 32'(dut.mem1_imag[i]), 32'(expI[i]));
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("%s_%0d", tag, i),
                        32'(dut.mem0_real[i] | dut.mem0_imag[i] | dut.mem1_real[i] | dut.mem1_imag[i]),
                        32'd0);
        end
    endtask

    initial begin
        int cyc;
        int sawDone;
        reset = 1'b0; enable = 1'b1; go = 1'b0;
        mem0_load = 1'b0; mem1_load = 1'b0;
        m0r1 = '0; m0i1 = '0; m0r2 = '0; m0i2 = '0;
        m1r1 = '0; m1i1 = '0; m1r2 = '0; m1i2 = '0;
        tick();
        tick();
        reset = 1'b1;
        checkOutput("reset_done", 32'(done), 32'd0);
        checkAllZero("reset_mem");

        // Impulse
        for (int i = 0; i < N; i++) begin inR[i] = '0; inI[i] = '0; end
        inR[0] = 16'h0100;
        applyStimulus();
        tick();
        startAndWait(1'b0, -1, 0, cyc);
        checkOutput("impulse_latency", 32'(cyc), 32'd12);
        computeModel();
        checkMem1("impulse");
        checkOutput("impulse_re5_const", 32'(dut.mem1_real[5]), 32'h0100);

        // Constant
        for (int i = 0; i < N; i++) begin inR[i] = 16'h0100; inI[i] = '0; end
        applyStimulus();
        tick();
        startAndWait(1'b0, -1, 0, cyc);
        checkOutput("const_latency", 32'(cyc), 32'd12);
        computeModel();
        checkMem1("const");
        checkOutput("const_re0", 32'(dut.mem1_real[0]), 32'h0800);

        // Mixed, go raised in the same cycle load drops
        inR = '{16'h0100, 16'hFFA5, 16'hFF80, 16'h005A, 16'h0000, 16'h005A, 16'hFF80, 16'hFFA5};
        for (int i = 0; i < N; i++) inI[i] = '0;
        applyStimulus();
        startAndWait(1'b0, -1, 0, cyc);
        checkOutput("mixed_latency", 32'(cyc), 32'd12);
        checkOutput("mixed_re0", 32'(dut.mem1_real[0]), 32'hFFFE);
        checkOutput("mixed_im0", 32'(dut.mem1_imag[0]), 32'h0000);
        computeModel();
        checkMem1("mixed");

        // Random vectors
        for (int r = 0; r < 3; r++) begin
            randomInput();
            applyStimulus();
            tick();
            startAndWait(1'b0, -1, 0, cyc);
            checkOutput($sformatf("rand%0d_latency", r), 32'(cyc), 32'd12);
            computeModel();
            checkMem1($sformatf("rand%0d", r));
        end

        // go held high across done must not restart
        randomInput();
        applyStimulus();
        tick();
        startAndWait(1'b1, -1, 0, cyc);
        checkOutput("hold_latency", 32'(cyc), 32'd12);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput($sformatf("hold_done_%0d", c), 32'(done), 32'd1);
        end
        computeModel();
        checkMem1("hold");
        go = 1'b0;
        tick();

        // go together with a load strobe is ignored
        mem0_load = 1'b1;
        go = 1'b1;
        tick();
        checkOutput("go_with_load", 32'(done), 32'd1);
        mem0_load = 1'b0;
        go = 1'b0;
        tick();
        checkOutput("go_with_load_after", 32'(done), 32'd1);

        // Enable low for three cycles mid-run
        randomInput();
        applyStimulus();
        tick();
        startAndWait(1'b0, 4, 3, cyc);
        checkOutput("stall_latency", 32'(cyc), 32'd15);
        computeModel();
        checkMem1("stall");

        // Reset in the middle of a run
        randomInput();
        applyStimulus();
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkAllZero("midreset_mem");
        sawDone = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done === 1'b1) sawDone = 1;
        end
        checkOutput("midreset_no_done", 32'(sawDone), 32'd0);
        randomInput();
        applyStimulus();
        tick();
        startAndWait(1'b0, -1, 0, cyc);
        checkOutput("postreset_latency", 32'(cyc), 32'd12);
        computeModel();
        checkMem1("postreset");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/fft_core.md
FFT_CORE -- requirements
Module: fft_core

Interface
REQ-001 Parameters SHALL be: N, default 8, transform length (power of two; RTL must be correct for 8); I, default 8, integer bits; F, default 8, fraction bits; word width W = I+F, signed two's complement Q(I).(F).
REQ-002 Ports, in order:
- clk  input  1  single clock, rising-edge.
- reset  input  1  synchronous active-low reset.
- enable  input  1  clock enable; when low, all state holds.
- go  input  1  start request.
- mem0_load, mem1_load  input  1 each  load strobes for memory 0 / memory 1.
- mem0_external_load1_real/_imag, mem0_external_load2_real/_imag  input  W each  two complex load words for mem0.
- mem1_external_load1_real/_imag, mem1_external_load2_real/_imag  input  W each  same for mem1.
- done  output  1  transform complete.
REQ-003 There SHALL be one clock domain; reset SHALL be synchronous and active-low.

Function
REQ-004 Two internal complex memories SHALL exist: mem0 and mem1, N entries each, separate real/imag arrays of W bits, named mem0_real, mem0_imag, mem1_real, mem1_imag.
REQ-005 Loading, with enable high and state IDLE or DONE: each cycle memX_load is high, load1 SHALL be written to memX[p] and load2 to memX[p+1]; p SHALL then advance by 2, wrapping mod N.
REQ-006 Each memory SHALL have its own pointer p; p SHALL return to 0 on any enabled cycle where that memory's load is low.
REQ-007 States SHALL be IDLE, RUN, DONE.
- IDLE/DONE -> RUN on an enabled edge where go=1 and both load strobes are 0.
- Load has priority: go is ignored while either strobe is high.
- go SHALL be edge-qualified: one go-low edge is required between starts; go held high after done does not restart.
REQ-008 RUN SHALL execute log2(N) stages of N/2 radix-2 DIT butterflies, one butterfly per enabled cycle, for (N/2)*log2(N) cycles total (12 for N=8).
REQ-009 Stage s = 0..log2(N)-1, butterfly b = 0..N/2-1:
- h = 2^s; top = (b>>s)*2h + (b & (h-1)); bot = top+h.
- Twiddle index k = (b & (h-1)) * N/(2h).
REQ-010 Memory routing:
- Stage 0 SHALL read mem0 at bitrev(top) and bitrev(bot) and write mem1.
- Later stages SHALL read the previous stage's destination at top/bot and write the other memory.
- For N=8 the final result SHALL be in mem1 in natural order; mem0 contents are overwritten.
REQ-011 Butterfly arithmetic: T = W_k*B; A' = A+T written at top; B' = A-T written at bot.
REQ-012 Complex multiply: four W x W signed products, summed per component, arithmetically shifted right by F (truncation), then truncated to W bits. Add/sub SHALL wrap in W bits, with no scaling or saturation.
REQ-013 Twiddle ROM W_k = cos(2*pi*k/N) - j*sin(2*pi*k/N), rounded to Q(I).(F). For N=8: k0=(0x0100,0x0000), k1=(0x00B5,0xFF4B), k2=(0x0000,0xFF00), k3=(0xFF4B,0xFF4B).
REQ-014 Timing of done:
- done SHALL be registered and rise at the edge that completes the last butterfly (12 enabled edges after the start edge for N=8).
- done SHALL stay high in DONE and clear on the edge entering RUN.
REQ-015 In RUN, load strobes and go SHALL be ignored.
REQ-016 enable low SHALL freeze the state, counters, memories and done.

Reset
REQ-017 When reset=0 at a rising edge, the block SHALL clear regardless of enable: state=IDLE, done=0, stage/butterfly counters=0, both load pointers=0, all memory entries=0.
REQ-018 Reset asserted mid-RUN SHALL abort the transform, and done SHALL NOT assert.

Verification
REQ-019 Impulse: load mem0 real = {0x0100,0,0,0,0,0,0,0}, imag 0, then go -> done high 12 cycles later; every mem1 entry = (0x0100, 0x0000).
REQ-020 Constant: mem0 real all 0x0100, then go -> mem1[0] = (0x0800, 0); mem1[1..7] = (0, 0).
REQ-021 Mixed: mem0 real = {0x0100,0xFFA5,0xFF80,0x005A,0x0000,0x005A,0xFF80,0xFFA5}, imag 0, with go raised in the same cycle load drops -> done high after 12 cycles; mem1_real[0] = 0xFFFE; mem1_imag[0] = 0; mem1 matches a bit-accurate model of REQ-009..013.
REQ-022 Controls: go held high after done -> no restart and done stays high; go while mem0_load=1 -> ignored; enable low for 3 cycles mid-RUN -> done delayed by exactly 3 cycles with an identical result.
REQ-023 Reset: assert reset low at RUN cycle 5 -> done=0, state IDLE, memories zero; a subsequent load+go gives the correct result.
